fp_seq_mult: RTL and testbench
==============================

# fp_seq_mult

Parametrised iterative shift-add unsigned multiplier for IEEE754 mantissa products. It takes two WIDTH-bit significands under a start/done handshake and produces the full 2·WIDTH-bit product. It also produces a normalised WIDTH-bit mantissa, a normalisation flag for exponent adjustment, and a sticky bit for downstream rounding. It sits in the multiply/square datapath between operand unpacking and the round/pack stage, and serves single (WIDTH=24) and double (WIDTH=53) precision.

## Interface
- WIDTH, 24, significand width in bits (hidden bit included); legal range 2..64.
- CW (localparam), $clog2(WIDTH+1), step-counter width.
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only when not busy.
- A  in  WIDTH  multiplier operand; its bits are consumed LSB first.
- B  in  WIDTH  multiplicand operand.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse; results are valid.
- prod  out  2·WIDTH  full product A·B.
- mant  out  WIDTH  normalised mantissa.
- norm  out  1  prod[2W-1]; downstream increments the exponent when set.
- sticky  out  1  OR of the product bits below mant.

## Operation
- FSM states: IDLE, RUN, DONE. Reset puts the FSM in IDLE.
- Reset values: busy=0, done=0, prod=0, mant=0, norm=0, sticky=0. All internal registers are cleared.
- IDLE or DONE with start=1 captures the operands at that edge:
  - lo=A, hi=0 (WIDTH+1 bits), mcand=B, cnt=WIDTH.
  - The FSM moves to RUN.
- RUN, each edge performs one step:
  - hi = hi + (lo[0] ? mcand : 0).
  - {hi,lo} is then shifted right by 1.
  - cnt is decremented.
- When cnt reaches 0, the FSM moves to DONE and the result registers load:
  - prod={hi[W-1:0],lo}.
  - norm=prod[2W-1].
  - mant = norm ? prod[2W-1:W] : prod[2W-2:W-1].
  - sticky = norm ? |prod[W-1:0] : |prod[W-2:0].
- DONE lasts one cycle; done=1 during it. The FSM returns to IDLE unless start=1, which begins a new operation back-to-back.
- busy = (state==RUN).
- start is ignored while in RUN; operands are not re-sampled.
- Result registers hold their values until the next operation completes.
- Arithmetic is unsigned. hi carries one guard bit so the add never overflows.
- Reset asserted mid-operation aborts the operation: no done pulse, and all outputs return to reset values.

## Timing
- Start accepted at edge 0; steps occur at edges 1..WIDTH.
- done is high in the cycle between edges WIDTH and WIDTH+1.
- Total latency is WIDTH+1 edges. Back-to-back throughput is one result per WIDTH+1 cycles.
- done and the outputs are registered with no combinational path from the inputs.

## Configuration
- FPMUL_EARLY_TERM_EN defined:
  - On a RUN edge where all unprocessed multiplier bits (lo[cnt-1:1] after the current step) are zero, the step completes in that same edge.
  - {hi,lo} is right-shifted by the remaining cnt-1 positions through a barrel shifter, and the FSM moves to DONE.
  - Minimum latency is 2 edges (step at edge 1, done in the next cycle). Results are bit-identical to the full-latency operation.
- FPMUL_EARLY_TERM_EN undefined: every operation takes exactly WIDTH steps and no barrel shifter is built.

## Test plan
- WIDTH=24, A=B=0x800000 -> prod=0x400000000000, norm=0, mant=0x800000, sticky=0, done at edge 24 after start.
- A=B=0xFFFFFF -> prod=0xFFFFFE000001, norm=1, mant=0xFFFFFE, sticky=1.
- A=B=0xC00000 -> prod=0x900000000000, norm=1, mant=0x900000, sticky=0. A second start in the DONE cycle is accepted, and the new result arrives 25 edges later.
- start pulsed during RUN with different operands -> ignored; the first result is unchanged and busy stays high.
- RST dropped at step 10 -> all outputs 0 and no done pulse. The next start gives the correct product.
- With FPMUL_EARLY_TERM_EN:
  - A=0x000001, B=0xABCDEF -> prod=0xABCDEF, done at edge 1.
  - A=0x800000 -> full 24 steps.
  - Without the macro, both cases take 24 steps.

Source files
------------

// File: rtl/fp_seq_mult.sv
// fp_seq_mult: iterative shift-add unsigned significand multiplier.
// Produces the full 2*WIDTH product plus a normalised mantissa, normalisation
// flag and sticky bit for the round/pack stage.
// Optional feature macro: FPMUL_EARLY_TERM_EN. When it is defined, the operation
// finishes as soon as the remaining multiplier bits are all zero, and a barrel
// shifter aligns the partial product.
module fp_seq_mult #(
    parameter int unsigned WIDTH = 24
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 start,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   prod,
    output logic [WIDTH-1:0]     mant,
    output logic                 norm,
    output logic                 sticky
);

    localparam int unsigned W  = WIDTH;
    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q;
    logic [W:0]      hi_q;
    logic [W-1:0]    lo_q;
    logic [W-1:0]    mcand_q;
    logic [CW-1:0]   cnt_q;
    logic            busy_q;
    logic            done_q;
    logic [PW-1:0]   prod_q;
    logic [W-1:0]    mant_q;
    logic            norm_q;
    logic            sticky_q;

    logic [W:0]      sum;
    logic [W:0]      hi_d;
    logic [W-1:0]    lo_d;
    logic [CW-1:0]   cnt_d;
    logic            last;
    logic [PW-1:0]   prod_d;
    logic [W-1:0]    mant_d;
    logic            norm_d;
    logic            sticky_d;
`ifdef FPMUL_EARLY_TERM_EN
    logic [W:0]      bit_pos;
    logic [W-1:0]    rem_mask;
`endif

    // One shift-add step, end-of-operation detection and result formatting.
    always_comb begin
        sum   = hi_q + (lo_q[0] ? {1'b0, mcand_q} : '0);
        hi_d  = {1'b0, sum[W:1]};
        lo_d  = {sum[0], lo_q[W-1:1]};
        cnt_d = cnt_q - CW'(1);
`ifdef FPMUL_EARLY_TERM_EN
        // Unprocessed multiplier bits are lo_q[cnt-1:1]; if all zero the
        // remaining steps are pure shifts, so finish them in one go.
        bit_pos  = (W+1)'(1) << cnt_q;
        rem_mask = W'(bit_pos - (W+1)'(1)) & ~W'(1);
        last     = (cnt_q == CW'(1)) || ((lo_q & rem_mask) == '0);
        prod_d   = {hi_d[W-1:0], lo_d} >> cnt_d;
`else
        last     = (cnt_q == CW'(1));
        prod_d   = {hi_d[W-1:0], lo_d};
`endif
        norm_d   = prod_d[PW-1];
        mant_d   = norm_d ? prod_d[PW-1:W] : prod_d[PW-2:W-1];
        sticky_d = norm_d ? |prod_d[W-1:0] : |prod_d[W-2:0];
    end

    // Control FSM with datapath and registered outputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= IDLE;
            hi_q     <= '0;
            lo_q     <= '0;
            mcand_q  <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            prod_q   <= '0;
            mant_q   <= '0;
            norm_q   <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        lo_q    <= A;
                        hi_q    <= '0;
                        mcand_q <= B;
                        cnt_q   <= CW'(W);
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                RUN: begin
                    hi_q  <= hi_d;
                    lo_q  <= lo_d;
                    cnt_q <= cnt_d;
                    if (last) begin
                        state_q  <= DONE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        prod_q   <= prod_d;
                        mant_q   <= mant_d;
                        norm_q   <= norm_d;
                        sticky_q <= sticky_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign prod   = prod_q;
    assign mant   = mant_q;
    assign norm   = norm_q;
    assign sticky = sticky_q;

endmodule

// File: tb/tb_fp_seq_mult.sv
// Directed self-checking bench for fp_seq_mult at WIDTH=24.
module tb_fp_seq_mult;

    localparam int unsigned W = 24;

    logic          CLK = 1'b0;
    logic          RST;
    logic          start;
    logic [W-1:0]  A;
    logic [W-1:0]  B;
    logic          busy;
    logic          done;
    logic [2*W-1:0] prod;
    logic [W-1:0]  mant;
    logic          norm;
    logic          sticky;

    fp_seq_mult #(.WIDTH(W)) dut (
        .CLK(CLK), .RST(RST), .start(start), .A(A), .B(B),
        .busy(busy), .done(done), .prod(prod), .mant(mant),
        .norm(norm), .sticky(sticky)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] prod;
        logic [W-1:0]   mant;
        logic           norm;
        logic           sticky;
        int             lat_et;
    } vec_t;

    vec_t vecs [9];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Issue start for one edge (edge 0 of the operation).
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        A = a;
        B = b;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Count edges until done is seen; -1 on timeout.
    task automatic wait_done(output int edges);
        edges = -1;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (done) begin
                edges = i;
                break;
            end
        end
    endtask

    function automatic int exp_lat(input int lat_et);
`ifdef FPMUL_EARLY_TERM_EN
        return lat_et;
`else
        return (lat_et < 0) ? 24 : 24;
`endif
    endfunction

    int lat;
    int lat2;
    int done_seen;

    initial begin
        vecs[0] = '{24'h800000, 24'h800000, 48'h400000000000, 24'h800000, 1'b0, 1'b0, 24};
        vecs[1] = '{24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001, 24'hFFFFFE, 1'b1, 1'b1, 24};
        vecs[2] = '{24'hC00000, 24'hC00000, 48'h900000000000, 24'h900000, 1'b1, 1'b0, 24};
        vecs[3] = '{24'h000001, 24'hABCDEF, 48'h000000ABCDEF, 24'h000001, 1'b0, 1'b1, 1};
        vecs[4] = '{24'h000000, 24'h000000, 48'h000000000000, 24'h000000, 1'b0, 1'b0, 1};
        vecs[5] = '{24'hFFFFFF, 24'h000001, 48'h000000FFFFFF, 24'h000001, 1'b0, 1'b1, 24};
        vecs[6] = '{24'h800001, 24'h800000, 48'h400000800000, 24'h800001, 1'b0, 1'b0, 24};
        vecs[7] = '{24'hFFFFFF, 24'h800000, 48'h7FFFFF800000, 24'hFFFFFF, 1'b0, 1'b0, 24};
        vecs[8] = '{24'hC00000, 24'h800000, 48'h600000000000, 24'hC00000, 1'b0, 1'b0, 24};

        RST = 1'b0;
        start = 1'b0;
        A = '0;
        B = '0;
        repeat (3) tick();
        check("reset busy",   64'(busy),   64'd0);
        check("reset done",   64'(done),   64'd0);
        check("reset prod",   64'(prod),   64'd0);
        check("reset mant",   64'(mant),   64'd0);
        check("reset norm",   64'(norm),   64'd0);
        check("reset sticky", 64'(sticky), 64'd0);
        RST = 1'b1;
        tick();

        // Table-driven vectors.
        for (int i = 0; i < 9; i++) begin
            start_op(vecs[i].a, vecs[i].b);
            check($sformatf("v%0d busy", i), 64'(busy), 64'd1);
            wait_done(lat);
            check($sformatf("v%0d latency", i), 64'(lat), 64'(exp_lat(vecs[i].lat_et)));
            check($sformatf("v%0d prod", i),   64'(prod),   64'(vecs[i].prod));
            check($sformatf("v%0d mant", i),   64'(mant),   64'(vecs[i].mant));
            check($sformatf("v%0d norm", i),   64'(norm),   64'(vecs[i].norm));
            check($sformatf("v%0d sticky", i), 64'(sticky), 64'(vecs[i].sticky));
            check($sformatf("v%0d busy in done", i), 64'(busy), 64'd0);
            tick();
            check($sformatf("v%0d done pulse", i), 64'(done), 64'd0);
            check($sformatf("v%0d prod hold", i),  64'(prod), 64'(vecs[i].prod));
        end

        // Back-to-back: restart during the DONE cycle.
        start_op(24'hC00000, 24'hC00000);
        wait_done(lat);
        check("b2b first latency", 64'(lat),  64'd24);
        check("b2b first prod",    64'(prod), 64'h900000000000);
        start_op(24'h800000, 24'h800000);
        check("b2b restart busy", 64'(busy), 64'd1);
        check("b2b restart done", 64'(done), 64'd0);
        check("b2b held prod",    64'(prod), 64'h900000000000);
        wait_done(lat2);
        check("b2b done spacing", 64'(lat2 + 1), 64'd25);
        check("b2b second prod",  64'(prod), 64'h400000000000);
        check("b2b second mant",  64'(mant), 64'h800000);
        tick();

        // start during RUN is ignored.
        start_op(24'hFFFFFF, 24'hFFFFFF);
        repeat (5) tick();
        A = 24'h800000;
        B = 24'h800000;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("run start busy", 64'(busy), 64'd1);
        wait_done(lat);
        check("run start latency", 64'(lat + 6), 64'd24);
        check("run start prod",    64'(prod),    64'hFFFFFE000001);
        check("run start mant",    64'(mant),    64'hFFFFFE);
        tick();
        check("run start no restart", 64'(busy), 64'd0);

        // Reset in the middle of an operation.
        start_op(24'h800000, 24'h800000);
        repeat (10) tick();
        RST = 1'b0;
        #1;
        check("abort busy",   64'(busy),   64'd0);
        check("abort done",   64'(done),   64'd0);
        check("abort prod",   64'(prod),   64'd0);
        check("abort mant",   64'(mant),   64'd0);
        check("abort norm",   64'(norm),   64'd0);
        check("abort sticky", 64'(sticky), 64'd0);
        tick();
        tick();
        RST = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (done) done_seen++;
        end
        check("abort no done", 64'(done_seen), 64'd0);
        start_op(24'hFFFFFF, 24'h000001);
        wait_done(lat);
        check("post abort latency", 64'(lat),    64'd24);
        check("post abort prod",    64'(prod),   64'h000000FFFFFF);
        check("post abort sticky",  64'(sticky), 64'd1);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
